// File: rtl/vdp_cmd_engine.sv
// VDP CPU port command engine: two-byte control protocol, autoincrementing
// address, read-ahead buffer, register/CRAM writes and req/ack VRAM access.
module vdp_cmd_engine #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned CRAM_AW  = 5,
  parameter int unsigned CRAM_DW  = 6,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned NUM_REGS = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               port_wr,
  input  logic               port_rd,
  input  logic               port_sel,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  input  logic [7:0]         status_in,
  output logic               status_rd_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_wdata,
  output logic               reg_we,
  output logic [REG_AW-1:0]  reg_addr,
  output logic [7:0]         reg_wdata,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned HI_W = ADDR_W - 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MEM_RD = 2'd1;
  localparam logic [1:0] MEM_WR = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               pending_q, pending_d;
  logic [1:0]         code_q, code_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         read_buf_q, read_buf_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               status_rd_ack_q, status_rd_ack_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic               cram_we_q, cram_we_d;
  logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
  logic [CRAM_DW-1:0] cram_wdata_q, cram_wdata_d;
  logic               reg_we_q, reg_we_d;
  logic [REG_AW-1:0]  reg_addr_q, reg_addr_d;
  logic [7:0]         reg_wdata_q, reg_wdata_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic [ADDR_W-1:0]  addr_inc;
  logic [ADDR_W-1:0]  addr_hi_upd;
  logic [REG_AW-1:0]  reg_idx;

  assign addr_inc    = addr_q + ADDR_W'(1);
  assign addr_hi_upd = {wdata[HI_W-1:0], addr_q[7:0]};
  assign reg_idx     = wdata[REG_AW-1:0];

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    code_d          = code_q;
    addr_d          = addr_q;
    read_buf_d      = read_buf_q;
    rdata_d         = rdata_q;
    status_rd_ack_d = 1'b0;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    cram_we_d       = 1'b0;
    cram_addr_d     = cram_addr_q;
    cram_wdata_d    = cram_wdata_q;
    reg_we_d        = 1'b0;
    reg_addr_d      = reg_addr_q;
    reg_wdata_d     = reg_wdata_q;
    overrun_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (port_wr && port_sel) begin
          if (!pending_q) begin
            addr_d[7:0] = wdata;
            pending_d   = 1'b1;
          end else begin
            pending_d = 1'b0;
            code_d    = wdata[7:6];
            addr_d    = addr_hi_upd;
            if (wdata[7:6] == 2'd0) begin
              state_d    = MEM_RD;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = addr_hi_upd;
            end else if (wdata[7:6] == 2'd2 && 32'(reg_idx) < NUM_REGS) begin
              reg_we_d    = 1'b1;
              reg_addr_d  = reg_idx;
              reg_wdata_d = addr_q[7:0];
            end
          end
        end else if (port_wr) begin
          pending_d  = 1'b0;
          read_buf_d = wdata;
          if (code_q == 2'd3) begin
            cram_we_d    = 1'b1;
            cram_addr_d  = addr_q[CRAM_AW-1:0];
            cram_wdata_d = wdata[CRAM_DW-1:0];
            addr_d       = addr_inc;
          end else begin
            state_d     = MEM_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata;
          end
        end else if (port_rd && port_sel) begin
          rdata_d         = status_in;
          status_rd_ack_d = 1'b1;
          pending_d       = 1'b0;
        end else if (port_rd) begin
          rdata_d    = read_buf_q;
          pending_d  = 1'b0;
          state_d    = MEM_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
        end
      end
      MEM_RD, MEM_WR: begin
        // Strobes during a VRAM transaction are dropped and flagged
        overrun_d = port_wr | port_rd;
        if (mem_ack) begin
          if (state_q == MEM_RD) read_buf_d = mem_rdata;
          addr_d    = addr_inc;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      pending_q       <= 1'b0;
      code_q          <= 2'd0;
      addr_q          <= '0;
      read_buf_q      <= 8'd0;
      rdata_q         <= 8'd0;
      status_rd_ack_q <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= 8'd0;
      cram_we_q       <= 1'b0;
      cram_addr_q     <= '0;
      cram_wdata_q    <= '0;
      reg_we_q        <= 1'b0;
      reg_addr_q      <= '0;
      reg_wdata_q     <= 8'd0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      code_q          <= code_d;
      addr_q          <= addr_d;
      read_buf_q      <= read_buf_d;
      rdata_q         <= rdata_d;
      status_rd_ack_q <= status_rd_ack_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cram_we_q       <= cram_we_d;
      cram_addr_q     <= cram_addr_d;
      cram_wdata_q    <= cram_wdata_d;
      reg_we_q        <= reg_we_d;
      reg_addr_q      <= reg_addr_d;
      reg_wdata_q     <= reg_wdata_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
    end
  end

  assign rdata         = rdata_q;
  assign status_rd_ack = status_rd_ack_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cram_we       = cram_we_q;
  assign cram_addr     = cram_addr_q;
  assign cram_wdata    = cram_wdata_q;
  assign reg_we        = reg_we_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_vdp_cmd_engine.sv
// Scoreboard bench for vdp_cmd_engine: directed protocol cases then random
// port traffic, checked against a command-level reference model.
module tb_vdp_cmd_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       port_wr, port_rd, port_sel;
  logic [7:0] wdata, rdata, status_in;
  logic       status_rd_ack;
  logic       mem_req, mem_we, mem_ack;
  logic [13:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       cram_we;
  logic [4:0] cram_addr;
  logic [5:0] cram_wdata;
  logic       reg_we;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       busy, overrun;

  vdp_cmd_engine dut (
    .clk(clk), .reset(reset), .port_wr(port_wr), .port_rd(port_rd),
    .port_sel(port_sel), .wdata(wdata), .rdata(rdata), .status_in(status_in),
    .status_rd_ack(status_rd_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .cram_we(cram_we), .cram_addr(cram_addr),
    .cram_wdata(cram_wdata), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  data;
  } mem_ev_t;

  mem_ev_t     q_mem[$];
  logic [10:0] q_cram[$];   // {addr[4:0], data[5:0]}
  logic [11:0] q_reg[$];    // {idx[3:0], data[7:0]}
  logic [7:0]  q_stat[$];
  int          exp_ovr;
  int          n_vec, n_err;

  logic [7:0]  vram[16384];
  logic [7:0]  mmem[16384];
  int          ack_delay;

  // Reference model state
  bit          m_pending;
  bit [1:0]    m_code;
  logic [13:0] m_addr;
  logic [7:0]  m_buf;
  bit          m_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_code = 0; m_addr = 0; m_buf = 0; m_busy = 0;
  endtask

  task automatic model_mem_read();
    q_mem.push_back(mem_ev_t'{we: 1'b0, addr: m_addr, data: mmem[m_addr]});
    m_buf  = mmem[m_addr];
    m_addr = m_addr + 14'd1;
    m_busy = 1;
  endtask

  task automatic model_ctrl_wr(input logic [7:0] d);
    if (!m_pending) begin
      m_addr[7:0] = d;
      m_pending = 1;
    end else begin
      m_pending = 0;
      m_code = d[7:6];
      m_addr[13:8] = d[5:0];
      if (m_code == 2'd0) model_mem_read();
      else if (m_code == 2'd2 && d[3:0] < 4'd11) q_reg.push_back({d[3:0], m_addr[7:0]});
    end
  endtask

  task automatic model_data_wr(input logic [7:0] d);
    m_pending = 0;
    m_buf = d;
    if (m_code == 2'd3) begin
      q_cram.push_back({m_addr[4:0], d[5:0]});
    end else begin
      q_mem.push_back(mem_ev_t'{we: 1'b1, addr: m_addr, data: d});
      mmem[m_addr] = d;
      m_busy = 1;
    end
    m_addr = m_addr + 14'd1;
  endtask

  // Apply one strobe for one cycle (called just after a negedge)
  task automatic do_op(input bit wr, input bit rd, input bit sel,
                       input logic [7:0] d, input logic [7:0] st);
    bit         chk_rd;
    logic [7:0] exp_rd;
    chk_rd = 0; exp_rd = 0;
    port_wr = wr; port_rd = rd; port_sel = sel; wdata = d; status_in = st;
    if (wr || rd) begin
      if (m_busy) exp_ovr++;
      else if (wr && sel) model_ctrl_wr(d);
      else if (wr) model_data_wr(d);
      else if (sel) begin q_stat.push_back(st); m_pending = 0; end
      else begin chk_rd = 1; exp_rd = m_buf; m_pending = 0; model_mem_read(); end
    end
    @(negedge clk);
    port_wr = 0; port_rd = 0;
    if (chk_rd) chk("rdata", 32'(rdata), 32'(exp_rd));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    m_busy = 0;
  endtask

  // VRAM responder with programmable ack latency
  task automatic responder();
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (reset || !mem_req) begin
        mem_ack = 1'b0; cnt = 0;
      end else if (!mem_ack) begin
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) vram[mem_addr] = mem_wdata;
          else mem_rdata = vram[mem_addr];
        end else cnt++;
      end
    end
  endtask

  // Output monitor: pops the per-channel expectation queues
  task automatic monitor();
    mem_ev_t     e;
    logic [10:0] c;
    logic [11:0] r;
    logic [7:0]  s;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req && mem_ack) begin
          if (q_mem.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
          else begin
            e = q_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_data", 32'(mem_we ? mem_wdata : mem_rdata), 32'(e.data));
          end
        end
        if (cram_we) begin
          if (q_cram.size() == 0) chk("cram_unexpected", 32'd1, 32'd0);
          else begin
            c = q_cram.pop_front();
            chk("cram_addr", 32'(cram_addr), 32'(c[10:6]));
            chk("cram_wdata", 32'(cram_wdata), 32'(c[5:0]));
          end
        end
        if (reg_we) begin
          if (q_reg.size() == 0) chk("reg_unexpected", 32'd1, 32'd0);
          else begin
            r = q_reg.pop_front();
            chk("reg_addr", 32'(reg_addr), 32'(r[11:8]));
            chk("reg_wdata", 32'(reg_wdata), 32'(r[7:0]));
          end
        end
        if (status_rd_ack) begin
          if (q_stat.size() == 0) chk("stat_unexpected", 32'd1, 32'd0);
          else begin
            s = q_stat.pop_front();
            chk("status_rdata", 32'(rdata), 32'(s));
          end
        end
        if (overrun) begin
          if (exp_ovr == 0) chk("overrun_unexpected", 32'd1, 32'd0);
          else begin
            chk("overrun", 32'(overrun), 32'd1);
            exp_ovr--;
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] x;
    n_vec = 0; n_err = 0; exp_ovr = 0; ack_delay = 0;
    reset = 1'b1; port_wr = 0; port_rd = 0; port_sel = 0;
    wdata = 0; status_in = 0; mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 16384; i++) begin
      x = 8'($urandom);
      vram[i] = x; mmem[i] = x;
    end
    vram[14'h0100] = 8'h11; mmem[14'h0100] = 8'h11;
    vram[14'h0101] = 8'h22; mmem[14'h0101] = 8'h22;
    model_reset();
    fork
      responder();
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({cram_we, reg_we, status_rd_ack, overrun}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Code 1 address then two VRAM writes
    do_op(1, 0, 1, 8'h34, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h52, 8'h00); wait_idle();
    do_op(1, 0, 0, 8'hAA, 8'h00); wait_idle();
    do_op(1, 0, 0, 8'hBB, 8'h00); wait_idle();
    // Prefetch and read-ahead
    do_op(1, 0, 1, 8'h00, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h01, 8'h00); wait_idle();
    do_op(0, 1, 0, 8'h00, 8'h00); wait_idle();
    do_op(0, 1, 0, 8'h00, 8'h00); wait_idle();
    // Register writes, one to an unimplemented index
    do_op(1, 0, 1, 8'h0F, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h87, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h0F, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h8C, 8'h00); wait_idle();
    // CRAM writes with address wrap
    do_op(1, 0, 1, 8'h1F, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'hC0, 8'h00); wait_idle();
    do_op(1, 0, 0, 8'hFF, 8'h00); wait_idle();
    do_op(1, 0, 0, 8'h12, 8'h00); wait_idle();
    // Status read clears pending
    do_op(1, 0, 1, 8'h55, 8'h00); wait_idle();
    do_op(0, 1, 1, 8'h00, 8'h80); wait_idle();
    do_op(1, 0, 1, 8'h66, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h40, 8'h00); wait_idle();
    do_op(1, 0, 0, 8'h9A, 8'h00); wait_idle();
    // Delayed ack at 0x3FFF with a dropped strobe, then wrap
    do_op(1, 0, 1, 8'hFF, 8'h00); wait_idle();
    do_op(1, 0, 1, 8'h7F, 8'h00); wait_idle();
    ack_delay = 3;
    do_op(1, 0, 0, 8'hC3, 8'h00);
    do_op(1, 0, 0, 8'h3C, 8'h00); wait_idle();
    ack_delay = 0;
    do_op(1, 0, 0, 8'h77, 8'h00); wait_idle();
    // Simultaneous write and read: write wins
    do_op(1, 1, 0, 8'h5E, 8'h00); wait_idle();

    // Reset while mem_req is held
    ack_delay = 10;
    do_op(1, 0, 0, 8'hE1, 8'h00);
    @(negedge clk);
    chk("req_held", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rdata", 32'(rdata), 32'd0);
    q_mem.delete();
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    do_op(0, 1, 0, 8'h00, 8'h00); wait_idle();
    do_op(1, 0, 0, 8'h5A, 8'h00); wait_idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      ack_delay = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      do_op(r < 55 || r >= 90, r >= 55, 1'($urandom), 8'($urandom), 8'($urandom));
      if (m_busy && $urandom_range(0, 5) == 0)
        do_op(1'($urandom), 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("q_mem_drained", 32'(q_mem.size()), 32'd0);
    chk("q_cram_drained", 32'(q_cram.size()), 32'd0);
    chk("q_reg_drained", 32'(q_reg.size()), 32'd0);
    chk("q_stat_drained", 32'(q_stat.size()), 32'd0);
    chk("ovr_drained", 32'(exp_ovr), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vdp_cmd_engine.md
Name: vdp_cmd_engine

Overview:
- Parametrised successor of the VDP control/data port logic.
- Accepts decoded CPU port strobes and implements the two-byte command protocol, autoincrementing address register, read-ahead buffer, register-file writes, CRAM writes and status reads.
- Sits between the I/O port decoder and the VDP storage.
- Reaches VRAM through a req/ack handshake so the renderer can share VRAM through an arbiter.

Parameters:
- ADDR_W, 14, VRAM address width; legal range 9..14.
- CRAM_AW, 5, CRAM address width.
- CRAM_DW, 6, CRAM data width (≤8).
- REG_AW, 4, register index width.
- NUM_REGS, 11, number of implemented VDP registers; indices ≥ NUM_REGS are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_wr  in  1  one-cycle CPU write strobe.
- port_rd  in  1  one-cycle CPU read strobe.
- port_sel  in  1  1 = control port, 0 = data port.
- wdata  in  8  CPU write byte.
- rdata  out  8  CPU read byte, registered.
- status_in  in  8  status byte from the renderer.
- status_rd_ack  out  1  one-cycle pulse telling the renderer to clear its status flags.
- mem_req  out  1  VRAM request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  8  VRAM write data.
- mem_ack  in  1  VRAM acknowledge.
- mem_rdata  in  8  VRAM read data, valid when mem_ack is high.
- cram_we  out  1  CRAM write pulse.
- cram_addr  out  CRAM_AW  CRAM address.
- cram_wdata  out  CRAM_DW  CRAM write data.
- reg_we  out  1  register write pulse.
- reg_addr  out  REG_AW  register index.
- reg_wdata  out  8  register data.
- busy  out  1  VRAM transaction outstanding.
- overrun  out  1  one-cycle pulse when a strobe is dropped.

Behaviour:

Internal state:
- pending (1 bit), code (2 bits), addr (ADDR_W bits), read_buf (8 bits).
- FSM states: IDLE, MEM_RD, MEM_WR.

Reset:
- Reset asserted at any time, including mid-transaction, clears everything asynchronously.
- FSM goes to IDLE; pending, code, addr and read_buf are 0.
- All outputs are 0, including mem_req.

Strobe acceptance:
- A strobe is accepted only in IDLE.
- A strobe arriving in MEM_RD or MEM_WR is dropped and pulses overrun on the next cycle.
- port_wr and port_rd high in the same cycle: the write is taken, the read is ignored, no overrun.

Control write, pending=0:
- addr[7:0] <= wdata.
- pending <= 1.

Control write, pending=1:
- code <= wdata[7:6].
- addr[ADDR_W-1:8] <= wdata[ADDR_W-9:0].
- pending <= 0.
- code 0: enter MEM_RD (prefetch).
- code 1: no further action.
- code 2: next cycle, reg_we=1 with reg_addr=wdata[REG_AW-1:0] and reg_wdata=addr[7:0]. No pulse if the index ≥ NUM_REGS. The address register is still updated.
- code 3: no further action.

Data write:
- pending <= 0.
- read_buf <= wdata.
- code 3: next cycle, cram_we=1 with cram_addr=addr[CRAM_AW-1:0] and cram_wdata=wdata[CRAM_DW-1:0]; then addr+1.
- Codes 0, 1, 2: enter MEM_WR with mem_addr=addr and mem_wdata=wdata.

Data read:
- rdata <= read_buf on the next edge.
- pending <= 0.
- Then enter MEM_RD to refill the buffer.

Control read:
- rdata <= status_in on the next edge.
- status_rd_ack pulses in that same cycle.
- pending <= 0.
- No memory access.

MEM_RD / MEM_WR handshake:
- mem_req is registered high on the cycle after acceptance.
- mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled high.
- On ack: MEM_RD captures read_buf <= mem_rdata. Both states then do addr <= addr+1, drop mem_req on the next edge and return to IDLE.
- Minimum turnaround with same-cycle ack: 2 cycles from strobe to IDLE.
- busy = (state != IDLE).

Address arithmetic:
- addr increments modulo 2^ADDR_W; 0x3FFF+1 → 0x0000 with default parameters.

Output hold:
- rdata holds its value until the next accepted read.
- Pulse outputs are high for exactly one cycle.

Test Plan:
- Reset, then ctrl write 0x34 then 0x52 (code 1, addr 0x1234). Data writes 0xAA, 0xBB with same-cycle ack → mem writes at 0x1234 then 0x1235; read_buf=0xBB; addr=0x1236.
- Preload VRAM[0x0100]=0x11, [0x0101]=0x22. Ctrl write 0x00, 0x01 → prefetch read at 0x0100. Data read → rdata=0x11, prefetch from 0x0101. Next data read → rdata=0x22.
- Ctrl write 0x0F, 0x87 → reg_we pulse, reg_addr=7, reg_wdata=0x0F. Ctrl write 0x0F, 0x8C (index 12 ≥ 11) → no reg_we.
- Ctrl write 0x1F, 0xC0 (code 3). Data write 0xFF → cram_we, cram_addr=31, cram_wdata=0x3F. Next data write → cram_addr=0 (wrap).
- Ctrl write 0x55 (pending=1), then ctrl read with status_in=0x80 → rdata=0x80, status_rd_ack pulse, pending cleared. Next ctrl write 0x66 is taken as a first byte.
- Address 0x3FFF, ack delayed 3 cycles: a data write issued during the delay → overrun pulse, no extra access. Wrap to 0x0000 after ack. Reset asserted during held mem_req → mem_req low immediately and all state 0.
